rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter: CNT_W, default 16, width of the accepted-write counter.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 v0  input  1  requester 0 (ALU writeback) valid.
REQ-005 a0  input  5  requester 0 destination register address.
REQ-006 d0  input  32  requester 0 write data.
REQ-007 r0  output  1  requester 0 ready; a transfer occurs when v0 and r0 are both 1 at posedge clk.
REQ-008 v1, a1, d1, r1  input/input/input/output  1/5/32/1  requester 1 (load writeback); same meaning as REQ-004..007.
REQ-009 hold  input  1  stall from the sequencer; blocks all grants while 1.
REQ-010 WE3  output  1  register-file write enable.
REQ-011 A3  output  5  register-file write address.
REQ-012 WD3  output  32  register-file write data.
REQ-013 gnt_id  output  1  requester whose write is currently on WE3/A3/WD3.
REQ-014 wr_count  output  CNT_W  number of accepted transfers, saturating.

Function
REQ-015 r0 and r1 SHALL be combinational from v0, v1, hold and the priority pointer; at most one of r0, r1 SHALL be 1 in any cycle.
REQ-016 When hold=1, r0=r1=0.
REQ-017 When hold=0 and exactly one requester is valid, that requester's ready SHALL be 1.
REQ-018 When hold=0 and both are valid, ready SHALL go to the requester not named by the priority pointer (round-robin).
REQ-019 The priority pointer SHALL update to the granted requester's index only on an accepted transfer; it is unchanged otherwise.
REQ-020 An accepted transfer SHALL drive WE3=1, A3=addr, WD3=data and gnt_id=index on the cycle after acceptance (1-cycle latency, registered outputs).
REQ-021 In any cycle with no accepted transfer on the previous edge, WE3 SHALL be 0, and A3, WD3 and gnt_id SHALL hold their last values.
REQ-022 Back-to-back transfers SHALL sustain one write per cycle with no bubble.
REQ-023 Equal addresses from both requesters need no special handling; they are serialized by arbitration, with the later write winning in the register file.
REQ-024 wr_count SHALL increment by 1 per accepted transfer and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-025 Requester rule: once v=1, the requester holds v, a and d stable until accepted. The arbiter does not check this rule.

Reset
REQ-026 While rst=0: WE3=0, A3=0, WD3=0, gnt_id=0, wr_count=0, and the priority pointer=1, so requester 0 wins the first contention.
REQ-027 Assertion of rst mid-transfer SHALL force WE3=0 asynchronously; the in-flight write is dropped.
REQ-028 r0 and r1 SHALL be 0 while rst=0.

Configuration
REQ-029 Macro RF_ZERO_PROTECT_EN. When defined, a transfer with address 0 is accepted and counted but SHALL produce WE3=0, leaving register 0 unchanged. When undefined, address 0 is written like any other address.

Structure
REQ-030 Package rf_ctrl_pkg SHALL hold: typedef rf_addr_t (5 bits), typedef rf_data_t (32 bits), and constants REQ_ALU=0, REQ_MEM=1.
REQ-031 Sub-module rr_arb2 SHALL contain the 2-way round-robin grant logic and the priority pointer; rf_write_arbiter holds the output registers and the counter.

Verification
REQ-032 Reset release, then v0=1 a0=5 d0=0xDEADBEEF for one cycle -> r0=1; next cycle WE3=1 A3=5 WD3=0xDEADBEEF gnt_id=0; wr_count=1.
REQ-033 v0 and v1 held at 1 for 4 cycles (a0=1, a1=2) -> grants alternate 0,1,0,1; WE3 stays 1 for 4 consecutive cycles; A3 sequence is 1,2,1,2.
REQ-034 Both valid with hold=1 for 3 cycles -> r0=r1=0 and WE3=0 throughout; after hold drops, requester 0 is granted first.
REQ-035 v1=1 a1=0 d1=0x1234 -> with RF_ZERO_PROTECT_EN: r1=1, WE3 stays 0, wr_count=1; without it: WE3=1 A3=0 WD3=0x1234.
REQ-036 CNT_W=2 with 5 accepted writes -> wr_count reads 1,2,3,3,3.
REQ-037 rst pulsed low during a cycle with WE3=1 -> WE3 drops immediately; after release, first contention is granted to requester 0.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared register-file write types and requester indices.
package rf_ctrl_pkg;

  typedef logic [4:0]  rf_addr_t;
  typedef logic [31:0] rf_data_t;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  function automatic logic addr_is_zero(input rf_addr_t addr);
    return (addr == 5'd0);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a priority pointer naming the last winner.
module rr_arb2
  import rf_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic v0,
  input  logic v1,
  input  logic hold,
  output logic r0,
  output logic r1,
  output logic accept,
  output logic gnt_idx
);

  logic ptr_q;
  logic ptr_d;

  // Ready generation: contention goes to the requester the pointer does not name.
  always_comb begin
    r0 = 1'b0;
    r1 = 1'b0;
    if (!rst || hold) begin
      r0 = 1'b0;
      r1 = 1'b0;
    end else if (v0 && v1) begin
      if (ptr_q == REQ_MEM) begin
        r0 = 1'b1;
      end else begin
        r1 = 1'b1;
      end
    end else begin
      r0 = v0;
      r1 = v1;
    end
  end

  assign accept  = r0 | r1;
  assign gnt_idx = r1 ? REQ_MEM : REQ_ALU;

  // Pointer follows the winner, only when a transfer is actually accepted.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = gnt_idx;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= REQ_MEM;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates ALU and load writebacks onto one register-file write port.
// Optional macro RF_ZERO_PROTECT_EN suppresses the write enable for address 0.
module rf_write_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             v0,
  input  rf_addr_t         a0,
  input  rf_data_t         d0,
  output logic             r0,
  input  logic             v1,
  input  rf_addr_t         a1,
  input  rf_data_t         d1,
  output logic             r1,
  input  logic             hold,
  output logic             WE3,
  output rf_addr_t         A3,
  output rf_data_t         WD3,
  output logic             gnt_id,
  output logic [CNT_W-1:0] wr_count
);

  logic     accept_s;
  logic     gnt_idx_s;
  rf_addr_t sel_addr_s;
  rf_data_t sel_data_s;

  logic             we_q,  we_d;
  rf_addr_t         a3_q,  a3_d;
  rf_data_t         wd3_q, wd3_d;
  logic             gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .v0      (v0),
    .v1      (v1),
    .hold    (hold),
    .r0      (r0),
    .r1      (r1),
    .accept  (accept_s),
    .gnt_idx (gnt_idx_s)
  );

  assign sel_addr_s = (gnt_idx_s == REQ_MEM) ? a1 : a0;
  assign sel_data_s = (gnt_idx_s == REQ_MEM) ? d1 : d0;

  // Next-state for the write port and the saturating transfer counter.
  always_comb begin
    we_d  = 1'b0;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    gnt_d = gnt_q;
    cnt_d = cnt_q;
    if (accept_s) begin
      we_d  = 1'b1;
      a3_d  = sel_addr_s;
      wd3_d = sel_data_s;
      gnt_d = gnt_idx_s;
`ifdef RF_ZERO_PROTECT_EN
      if (addr_is_zero(sel_addr_s)) begin
        we_d = 1'b0;
      end else begin
        we_d = 1'b1;
      end
`endif
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      we_d = 1'b0;
    end
  end

  // Output registers; async reset drops any in-flight write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q  <= 1'b0;
      a3_q  <= 5'd0;
      wd3_q <= 32'd0;
      gnt_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      we_q  <= we_d;
      a3_q  <= a3_d;
      wd3_q <= wd3_d;
      gnt_q <= gnt_d;
      cnt_q <= cnt_d;
    end
  end

  assign WE3      = we_q;
  assign A3       = a3_q;
  assign WD3      = wd3_q;
  assign gnt_id   = gnt_q;
  assign wr_count = cnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed table-driven bench for rf_write_arbiter (default and CNT_W=2 instances).
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0, hold = 1'b0;
  logic [4:0]  a0 = 5'd0, a1 = 5'd0;
  logic [31:0] d0 = 32'd0, d1 = 32'd0;

  logic        r0, r1, WE3, gnt_id;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [15:0] wr_count;

  logic        r0_2, r1_2, WE3_2, gnt_id_2;
  logic [4:0]  A3_2;
  logic [31:0] WD3_2;
  logic [1:0]  wr_count_2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_write_arbiter dut (
    .clk(clk), .rst(rst),
    .v0(v0), .a0(a0), .d0(d0), .r0(r0),
    .v1(v1), .a1(a1), .d1(d1), .r1(r1),
    .hold(hold), .WE3(WE3), .A3(A3), .WD3(WD3),
    .gnt_id(gnt_id), .wr_count(wr_count)
  );

  rf_write_arbiter #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .v0(v0), .a0(a0), .d0(d0), .r0(r0_2),
    .v1(v1), .a1(a1), .d1(d1), .r1(r1_2),
    .hold(hold), .WE3(WE3_2), .A3(A3_2), .WD3(WD3_2),
    .gnt_id(gnt_id_2), .wr_count(wr_count_2)
  );

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        hold;
    logic        er0;
    logic        er1;
    logic        ewe;
    logic [4:0]  ea3;
    logic [31:0] ewd;
    logic        egnt;
    logic [15:0] ecnt;
    logic [1:0]  ecnt2;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0,    1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 16'd1, 2'd1};
    tbl[1]  = '{1'b0, 5'd0, 32'd0,        1'b1, 5'd3, 32'h33,   1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'h33,       1'b1, 16'd2, 2'd2};
    tbl[2]  = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,    1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 32'h33,       1'b1, 16'd2, 2'd2};
    tbl[3]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,   1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 32'h11,       1'b0, 16'd3, 2'd3};
    tbl[4]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,   1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h22,       1'b1, 16'd4, 2'd3};
    tbl[5]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,   1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 32'h11,       1'b0, 16'd5, 2'd3};
    tbl[6]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,   1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h22,       1'b1, 16'd6, 2'd3};
    tbl[7]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,   1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 32'h22,       1'b1, 16'd6, 2'd3};
    tbl[8]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,   1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 32'h22,       1'b1, 16'd6, 2'd3};
    tbl[9]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,   1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 32'h22,       1'b1, 16'd6, 2'd3};
    tbl[10] = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,   1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 32'h11,       1'b0, 16'd7, 2'd3};

    // Reset state with a requester already valid.
    v0 = 1'b1;
    #12;
    chk("rst_r0", {31'd0, r0}, 32'd0);
    chk("rst_r1", {31'd0, r1}, 32'd0);
    chk("rst_we", {31'd0, WE3}, 32'd0);
    chk("rst_a3", {27'd0, A3}, 32'd0);
    chk("rst_wd", WD3, 32'd0);
    chk("rst_gnt", {31'd0, gnt_id}, 32'd0);
    chk("rst_cnt", {16'd0, wr_count}, 32'd0);
    v0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      v0 = tbl[i].v0; a0 = tbl[i].a0; d0 = tbl[i].d0;
      v1 = tbl[i].v1; a1 = tbl[i].a1; d1 = tbl[i].d1;
      hold = tbl[i].hold;
      #1;
      chk($sformatf("v%0d_r0", i), {31'd0, r0}, {31'd0, tbl[i].er0});
      chk($sformatf("v%0d_r1", i), {31'd0, r1}, {31'd0, tbl[i].er1});
      chk($sformatf("v%0d_r0_w2", i), {31'd0, r0_2}, {31'd0, tbl[i].er0});
      chk($sformatf("v%0d_r1_w2", i), {31'd0, r1_2}, {31'd0, tbl[i].er1});
      @(posedge clk); #1;
      chk($sformatf("v%0d_we", i), {31'd0, WE3}, {31'd0, tbl[i].ewe});
      chk($sformatf("v%0d_a3", i), {27'd0, A3}, {27'd0, tbl[i].ea3});
      chk($sformatf("v%0d_wd", i), WD3, tbl[i].ewd);
      chk($sformatf("v%0d_gnt", i), {31'd0, gnt_id}, {31'd0, tbl[i].egnt});
      chk($sformatf("v%0d_cnt", i), {16'd0, wr_count}, {16'd0, tbl[i].ecnt});
      chk($sformatf("v%0d_we_w2", i), {31'd0, WE3_2}, {31'd0, tbl[i].ewe});
      chk($sformatf("v%0d_a3_w2", i), {27'd0, A3_2}, {27'd0, tbl[i].ea3});
      chk($sformatf("v%0d_wd_w2", i), WD3_2, tbl[i].ewd);
      chk($sformatf("v%0d_gnt_w2", i), {31'd0, gnt_id_2}, {31'd0, tbl[i].egnt});
      chk($sformatf("v%0d_cnt_w2", i), {30'd0, wr_count_2}, {30'd0, tbl[i].ecnt2});
    end

    // Address-0 write from requester 1.
    v0 = 1'b0; hold = 1'b0;
    v1 = 1'b1; a1 = 5'd0; d1 = 32'h1234;
    #1;
    chk("z_r0", {31'd0, r0}, 32'd0);
    chk("z_r1", {31'd0, r1}, 32'd1);
    @(posedge clk); #1;
    chk("z_cnt", {16'd0, wr_count}, 32'd8);
`ifdef RF_ZERO_PROTECT_EN
    chk("z_we", {31'd0, WE3}, 32'd0);
`else
    chk("z_we", {31'd0, WE3}, 32'd1);
    chk("z_a3", {27'd0, A3}, 32'd0);
    chk("z_wd", WD3, 32'h1234);
    chk("z_gnt", {31'd0, gnt_id}, 32'd1);
`endif
    v1 = 1'b0;

    // Reset pulsed while a write is on the port.
    v0 = 1'b1; a0 = 5'd9; d0 = 32'h99;
    @(posedge clk); #1;
    chk("mr_we_pre", {31'd0, WE3}, 32'd1);
    chk("mr_a3_pre", {27'd0, A3}, 32'd9);
    rst = 1'b0;
    #1;
    chk("mr_we_drop", {31'd0, WE3}, 32'd0);
    chk("mr_a3_clr", {27'd0, A3}, 32'd0);
    chk("mr_cnt_clr", {16'd0, wr_count}, 32'd0);
    chk("mr_r0_low", {31'd0, r0}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    v1 = 1'b1; a1 = 5'd7; d1 = 32'h77;
    #1;
    chk("mr_first_r0", {31'd0, r0}, 32'd1);
    chk("mr_first_r1", {31'd0, r1}, 32'd0);
    @(posedge clk); #1;
    chk("mr_first_gnt", {31'd0, gnt_id}, 32'd0);
    chk("mr_first_a3", {27'd0, A3}, 32'd9);
    chk("mr_first_cnt", {16'd0, wr_count}, 32'd1);
    v0 = 1'b0; v1 = 1'b0;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
